mux_rr_nx1: RTL and testbench
=============================

# mux_rr_nx1

Parametrised N-input, WIDTH-bit channel multiplexer with valid/ready handshakes on every input and on the output, plus a registered output stage. It succeeds the fixed 4-to-1 single-bit select mux. It adds a runtime mode input:

- **Manual mode:** the external select chooses the channel.
- **Round-robin mode:** fair arbitration among requesting channels.

It sits between several producers and one shared consumer, such as a shared bus or a single datapath port.

## Interface
- `N`, default 4: number of input channels; must be ≥ 2.
- `WIDTH`, default 8: data width per channel in bits.
- `SELW`, default `$clog2(N)`: width of the select and channel-index fields.

Ports:
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `mode`  in  1  0 = manual select, 1 = round-robin.
- `sel`  in  SELW  channel index used in manual mode; ignored in round-robin mode.
- `in_valid`  in  N  per-channel request; bit i is channel i.
- `in_data`  in  N*WIDTH  packed data; channel i occupies `[i*WIDTH +: WIDTH]`.
- `in_ready`  out  N  per-channel accept, combinational; at most one bit high per cycle.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  WIDTH  held beat data.
- `out_ch`  out  SELW  index of the channel the held beat came from.
- `out_ready`  in  1  consumer accepts the held beat this cycle.

## Operation
- **Output register.** It has two states:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- **Space signal.** `space` = !`out_valid` | `out_ready`. New data may load only when `space` = 1.
- **Manual mode** (`mode` = 0):
  - Grant goes to channel `sel`, only if `in_valid[sel]` = 1.
  - If `sel` ≥ N, there is no grant.
- **Round-robin mode** (`mode` = 1):
  - Search starts at index (`last` + 1) mod N and wraps through all N channels.
  - The first channel with `in_valid` set wins.
- **Grant and accept.**
  - `in_ready[g]` = `space` & grant_valid; all other `in_ready` bits are 0.
  - A transfer on channel g occurs when `in_valid[g]` & `in_ready[g]`.
- **On a transfer:**
  - `out_data` ← `in_data` of channel g.
  - `out_ch` ← g.
  - `out_valid` ← 1.
  - `last` ← g. This update happens in both modes, so switching to round-robin continues fairly from the last served channel.
- **On output accept with no new load:** `out_valid` ← 0. `out_data` and `out_ch` hold their values.
- **Simultaneous events.** When FULL and `out_ready` = 1 with a granted request in the same cycle, the old beat leaves and the new beat loads. `out_valid` stays 1 and no bubble is inserted.
- **Backpressure.** When FULL and `out_ready` = 0:
  - All `in_ready` bits are 0.
  - `out_data` and `out_ch` stay stable.
  - Changes on `mode`, `sel`, or `in_*` do not affect the held beat.
- **Arbitration timing.** `mode` and `sel` are sampled combinationally each cycle. Arbitration never depends on a beat already held.

## Timing
- Latency is 1 cycle: data accepted at edge k appears on `out_*` after edge k.
- Throughput is 1 beat per cycle while `out_ready` = 1 and requests are present.
- `in_ready` depends combinationally on `out_ready`, `in_valid`, `mode`, `sel`, and `last`. There is no combinational path from `in_data` to any output.
- **Reset** (synchronous, `rst` = 1 at a rising edge):
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0.
  - `last` = N−1, so channel 0 has first priority.
  - While `rst` = 1, `in_ready` = 0.
  - Asserting reset mid-operation discards any held beat with no handshake to the consumer.
- Round-robin fairness: with all N channels requesting continuously and `out_ready` = 1, each channel is served exactly once in every N consecutive cycles.

## Test plan
- **Reset:** hold `rst` 2 cycles with all `in_valid` = 1 → `out_valid`/`out_data`/`out_ch` = 0 and `in_ready` = 0 throughout. The first beat after release comes from channel 0 (round-robin).
- **Manual mode** (N=4, WIDTH=8): `mode` = 0; `in_data` = {0x44, 0x33, 0x22, 0x11}; step `sel` 0→1→2→3 with all valid and `out_ready` = 1 → `out_data` = 0x11, 0x22, 0x33, 0x44 one cycle later, with `out_ch` = 0..3. Then `sel` = 2 with `in_valid[2]` = 0 → no `in_ready`, and `out_valid` drops.
- **Round-robin fairness:** `mode` = 1, all valid, `out_ready` = 1 for 8 cycles → `out_ch` = 0,1,2,3,0,1,2,3. With only channels 1 and 3 valid → `out_ch` alternates 1,3,1,3.
- **Backpressure:** FULL with `out_ch` = 2 and `out_data` = 0x33; hold `out_ready` = 0 for 3 cycles while changing `sel`/`mode` → `out_data` = 0x33 and `out_ch` = 2 stay stable, `in_ready` = 0. Release `out_ready` → the held beat leaves and the next grant loads in the same edge, with no bubble.
- **Mid-operation reset:** FULL with 0x22, assert `rst` for 1 cycle → `out_valid` = 0 next cycle and the beat is dropped. The next round-robin grant starts at channel 0.
- **Mode switch:** serve channel 2 in manual mode, then switch to `mode` = 1 with all valid → the next `out_ch` sequence is 3,0,1,2.

Source files
------------

// File: rtl/mux_rr_nx1.sv
// N-to-1 valid/ready channel mux: manual select or round-robin arbitration, registered output.
// Latency: one cycle from input accept to out_valid/out_data/out_ch.
// Backpressure: in_ready is held low while the output register is full and out_ready is low.
module mux_rr_nx1 #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  input  logic               out_ready
);

  // Channel count at index width plus one bit, so sel >= N and the
  // rotating index sum can be compared without truncation.
  localparam logic [SELW:0] NUM = (SELW+1)'(N);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SELW-1:0]   last;
  logic [SELW-1:0]   gnt_idx;
  logic              gnt_vld;
  logic              space;
  logic              load;
  logic [WIDTH-1:0]  gnt_dat;

  // Arbitration: manual picks sel if it is in range and requesting; round-robin
  // scans from the farthest to the nearest channel after last, so the nearest
  // requester overwrites the others and wins.
  always_comb begin : arb
    logic [SELW:0] sum;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    if (!mode) begin
      if (({1'b0, sel} < NUM) && in_valid[sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel;
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        sum = {1'b0, last} + {1'b0, SELW'(k)};
        if (sum >= NUM) sum = sum - NUM;
        if (in_valid[sum[SELW-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = sum[SELW-1:0];
        end
      end
    end
  end

  assign space     = (state == EMPTY) | out_ready;
  assign load      = gnt_vld & space & ~rst;
  assign out_valid = (state == FULL);

  // One-hot accept for the granted channel; never asserted during reset.
  always_comb begin
    in_ready = '0;
    if (load) in_ready[gnt_idx] = 1'b1;
  end

  // Data selection for the granted channel (only feeds the output register).
  always_comb begin
    gnt_dat = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i)) gnt_dat = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register occupancy: a load keeps/makes it FULL, an accept alone empties it.
  always_comb begin
    state_nxt = state;
    if (load)           state_nxt = FULL;
    else if (out_ready) state_nxt = EMPTY;
  end

  // Occupancy register; reset drops any held beat without a handshake.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Beat payload, source index and round-robin pointer; last starts at N-1 so channel 0 leads.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_ch   <= '0;
      last     <= SELW'(N-1);
    end else if (load) begin
      out_data <= gnt_dat;
      out_ch   <= gnt_idx;
      last     <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Bench for mux_rr_nx1: directed vector table, a held-beat stability sequence,
// and randomized traffic against a distance-based arbitration model.
module tb_mux_rr_nx1;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_ch;
  logic               out_ready;

  always #5 clk = ~clk;

  mux_rr_nx1 #(.N(N), .WIDTH(WIDTH), .SELW(SELW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            r;
    logic            m;
    logic [SELW-1:0] s;
    logic [N-1:0]    v;
    logic            o;
    logic [N-1:0]    er;
    logic            ev;
    logic [SELW-1:0] ec;
    logic [WIDTH-1:0] ed;
  } vec_t;

  vec_t tbl[64];
  int   ntbl = 0;

  task automatic add(input logic r, input logic m, input logic [SELW-1:0] s, input logic [N-1:0] v,
                     input logic o, input logic [N-1:0] er, input logic ev,
                     input logic [SELW-1:0] ec, input logic [WIDTH-1:0] ed);
    tbl[ntbl] = '{r, m, s, v, o, er, ev, ec, ed};
    ntbl++;
  endtask

  // Reference model state
  bit               m_full;
  logic [WIDTH-1:0] m_data;
  int               m_ch;
  int               m_last;

  // Winner = requester at the smallest rotational distance after last.
  function automatic int model_pick();
    int best, bestd, d;
    if (rst) return -1;
    if (m_full && !out_ready) return -1;
    if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i]) begin
        d = (i - m_last - 1 + 2*N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  initial begin
    logic [N*WIDTH-1:0] saved;
    logic [N-1:0]       er;
    int                 g;

    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;

    // Reset held two cycles with all channels requesting
    add(1'b1,1'b1,2'd0,4'hF,1'b1, 4'h0,1'b0,2'd0,8'h00);
    add(1'b1,1'b1,2'd0,4'hF,1'b1, 4'h0,1'b0,2'd0,8'h00);
    add(1'b0,1'b1,2'd0,4'hF,1'b1, 4'h1,1'b1,2'd0,8'h11);
    // Manual stepping sel 0..3, then an idle selected channel
    add(1'b0,1'b0,2'd0,4'hF,1'b1, 4'h1,1'b1,2'd0,8'h11);
    add(1'b0,1'b0,2'd1,4'hF,1'b1, 4'h2,1'b1,2'd1,8'h22);
    add(1'b0,1'b0,2'd2,4'hF,1'b1, 4'h4,1'b1,2'd2,8'h33);
    add(1'b0,1'b0,2'd3,4'hF,1'b1, 4'h8,1'b1,2'd3,8'h44);
    add(1'b0,1'b0,2'd2,4'hB,1'b1, 4'h0,1'b0,2'd3,8'h44);
    // Round-robin fairness, all requesting for 8 cycles
    for (int k = 0; k < 8; k++)
      add(1'b0,1'b1,2'd0,4'hF,1'b1, 4'(1 << (k % 4)),1'b1,2'(k % 4),8'(8'h11 * ((k % 4) + 1)));
    // Only channels 1 and 3 requesting
    add(1'b0,1'b1,2'd0,4'hA,1'b1, 4'h2,1'b1,2'd1,8'h22);
    add(1'b0,1'b1,2'd0,4'hA,1'b1, 4'h8,1'b1,2'd3,8'h44);
    add(1'b0,1'b1,2'd0,4'hA,1'b1, 4'h2,1'b1,2'd1,8'h22);
    add(1'b0,1'b1,2'd0,4'hA,1'b1, 4'h8,1'b1,2'd3,8'h44);
    // Backpressure on a held channel-2 beat, then release with no bubble
    add(1'b0,1'b0,2'd2,4'hF,1'b1, 4'h4,1'b1,2'd2,8'h33);
    add(1'b0,1'b1,2'd0,4'hF,1'b0, 4'h0,1'b1,2'd2,8'h33);
    add(1'b0,1'b0,2'd3,4'hF,1'b0, 4'h0,1'b1,2'd2,8'h33);
    add(1'b0,1'b1,2'd1,4'h5,1'b0, 4'h0,1'b1,2'd2,8'h33);
    add(1'b0,1'b1,2'd0,4'hF,1'b1, 4'h8,1'b1,2'd3,8'h44);
    // Mid-operation reset drops a held 0x22 beat; next RR grant is channel 0
    add(1'b0,1'b0,2'd1,4'hF,1'b1, 4'h2,1'b1,2'd1,8'h22);
    add(1'b1,1'b0,2'd1,4'hF,1'b0, 4'h0,1'b0,2'd0,8'h00);
    add(1'b0,1'b1,2'd0,4'hF,1'b1, 4'h1,1'b1,2'd0,8'h11);
    // Manual serve of channel 2, then round-robin continues 3,0,1,2
    add(1'b0,1'b0,2'd2,4'hF,1'b1, 4'h4,1'b1,2'd2,8'h33);
    add(1'b0,1'b1,2'd0,4'hF,1'b1, 4'h8,1'b1,2'd3,8'h44);
    add(1'b0,1'b1,2'd0,4'hF,1'b1, 4'h1,1'b1,2'd0,8'h11);
    add(1'b0,1'b1,2'd0,4'hF,1'b1, 4'h2,1'b1,2'd1,8'h22);
    add(1'b0,1'b1,2'd0,4'hF,1'b1, 4'h4,1'b1,2'd2,8'h33);
    // Drain with no requests (payload holds), then load into an empty register while out_ready=0
    add(1'b0,1'b1,2'd0,4'h0,1'b1, 4'h0,1'b0,2'd2,8'h33);
    add(1'b0,1'b1,2'd0,4'h1,1'b0, 4'h1,1'b1,2'd0,8'h11);

    for (int i = 0; i < ntbl; i++) begin
      @(negedge clk);
      rst = tbl[i].r; mode = tbl[i].m; sel = tbl[i].s; in_valid = tbl[i].v;
      out_ready = tbl[i].o; in_data = 32'h44332211;
      #1 chk($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].er));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d out_ch", i),    32'(out_ch),    32'(tbl[i].ec));
      chk($sformatf("tbl%0d out_data", i),  32'(out_data),  32'(tbl[i].ed));
    end

    // Held beat (ch0, 0x11) stays put while data, sel and mode churn under backpressure
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 4'hF; in_data = $urandom;
      mode = 1'($urandom_range(0, 1)); sel = 2'($urandom_range(0, 3));
      #1 chk("hold in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk("hold out_valid", 32'(out_valid), 32'h1);
      chk("hold out_ch",    32'(out_ch),    32'h0);
      chk("hold out_data",  32'(out_data),  32'h11);
    end
    @(negedge clk);
    out_ready = 1'b1; mode = 1'b1; in_valid = 4'hF; saved = $urandom; in_data = saved;
    #1 chk("release in_ready", 32'(in_ready), 32'h2);
    @(posedge clk); #1;
    chk("release out_valid", 32'(out_valid), 32'h1);
    chk("release out_ch",    32'(out_ch),    32'h1);
    chk("release out_data",  32'(out_data),  32'(saved[15:8]));

    // Randomized traffic; the first cycle is a reset to align the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst       = (i == 0) || ($urandom_range(0, 63) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      g  = (i == 0) ? -1 : model_pick();
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      #1 if (i != 0) chk("rnd in_ready", 32'(in_ready), 32'(er));
      @(posedge clk);
      if (rst) begin
        m_full = 1'b0; m_data = '0; m_ch = 0; m_last = N - 1;
      end else if (g >= 0) begin
        m_full = 1'b1; m_data = in_data[g*WIDTH +: WIDTH]; m_ch = g; m_last = g;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
      #1;
      chk("rnd out_valid", 32'(out_valid), 32'(m_full));
      chk("rnd out_ch",    32'(out_ch),    32'(m_ch));
      chk("rnd out_data",  32'(out_data),  32'(m_data));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
